// File: rtl/matrix_stream_bridge_pkg.sv
// Shared defaults, element counts and FSM state encoding for the matrix stream bridge.
package mm_pkg;

    localparam int MATRIX_SIZE_DEF = 3;
    localparam int DATA_SIZE_DEF   = 8;
    localparam int ELEM_COUNT      = MATRIX_SIZE_DEF * MATRIX_SIZE_DEF;
    localparam int LOAD_COUNT      = 2 * ELEM_COUNT;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_START,
        ST_CAPTURE,
        ST_DRAIN,
        ST_RELEASE
    } state_t;

endpackage

// File: rtl/matrix_stream_bridge_if.sv
// Operand-in / result-out stream handshake bundle; slave is the bridge side.
interface matrix_stream_bridge_if
    import mm_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF
) ();

    logic [DATA_SIZE-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_SIZE-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/matrix_stream_bridge.sv
// Streams A then B into operand stores, hands them to the multiply controller,
// then streams the captured product back out in row-major order.
module matrix_stream_bridge
    import mm_pkg::*;
#(
    parameter int MATRIX_SIZE = MATRIX_SIZE_DEF,
    parameter int DATA_SIZE   = DATA_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_stream_bridge_if.slave bus,
    output logic                 mm_start,
    input  logic                 mm_done,
    output logic                 busy,
    output logic [DATA_SIZE-1:0] store_a [MATRIX_SIZE][MATRIX_SIZE],
    output logic [DATA_SIZE-1:0] store_b [MATRIX_SIZE][MATRIX_SIZE],
    input  logic [DATA_SIZE-1:0] result  [MATRIX_SIZE*MATRIX_SIZE]
);

    localparam int NN  = MATRIX_SIZE * MATRIX_SIZE;
    localparam int NN2 = 2 * NN;
    localparam int CW  = $clog2(NN2) + 1;
    localparam int JW  = $clog2(NN) + 1;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [JW-1:0]        j;
    logic [JW-1:0]        j_next;
    logic [DATA_SIZE-1:0] buffer [NN];

    assign j_next = j + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_LOAD;
            cnt         <= '0;
            j           <= '0;
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_last  <= 1'b0;
            bus.m_data  <= '0;
            mm_start    <= 1'b0;
            busy        <= 1'b0;
            for (int r = 0; r < MATRIX_SIZE; r++) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    store_a[r][c] <= '0;
                    store_b[r][c] <= '0;
                end
            end
            for (int i = 0; i < NN; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    bus.s_ready <= 1'b1;
                    if (bus.s_valid && bus.s_ready) begin
                        // The first N*N transfers fill A, the next N*N fill B.
                        for (int r = 0; r < MATRIX_SIZE; r++) begin
                            for (int c = 0; c < MATRIX_SIZE; c++) begin
                                if (cnt == CW'(r * MATRIX_SIZE + c))
                                    store_a[r][c] <= bus.s_data;
                                if (cnt == CW'(NN + r * MATRIX_SIZE + c))
                                    store_b[r][c] <= bus.s_data;
                            end
                        end
                        if (cnt == CW'(NN2 - 1)) begin
                            cnt         <= '0;
                            bus.s_ready <= 1'b0;
                            mm_start    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    if (mm_done) begin
                        mm_start <= 1'b0;
                        state    <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    for (int i = 0; i < NN; i++) begin
                        buffer[i] <= result[i];
                    end
                    // Present element 0 straight from the product bus; the buffer is loading this edge.
                    bus.m_data  <= result[0];
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= (NN == 1);
                    j           <= '0;
                    state       <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.m_valid && bus.m_ready) begin
                        if (j == JW'(NN - 1)) begin
                            bus.m_valid <= 1'b0;
                            bus.m_last  <= 1'b0;
                            state       <= ST_RELEASE;
                        end else begin
                            j <= j_next;
                            for (int i = 0; i < NN; i++) begin
                                if (j_next == JW'(i))
                                    bus.m_data <= buffer[i];
                            end
                            bus.m_last <= (j_next == JW'(NN - 1));
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!mm_done) begin
                        cnt         <= '0;
                        bus.s_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_bridge.sv
// Self-checking bench: randomized matrices against a row-major product model,
// plus directed latency, gap, stall, mid-drain reset and back-to-back cases.
module tb_matrix_stream_bridge;
    import mm_pkg::*;

    localparam int N  = MATRIX_SIZE_DEF;
    localparam int W  = DATA_SIZE_DEF;
    localparam int NN = ELEM_COUNT;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic mm_start, mm_done, busy;
    logic [W-1:0] store_a [N][N];
    logic [W-1:0] store_b [N][N];
    logic [W-1:0] result  [NN];

    matrix_stream_bridge_if #(.DATA_SIZE(W)) bus ();

    matrix_stream_bridge #(.MATRIX_SIZE(N), .DATA_SIZE(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .busy     (busy),
        .store_a  (store_a),
        .store_b  (store_b),
        .result   (result)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [W-1:0] ta [N][N];
    logic [W-1:0] tbm [N][N];
    exp_t         exp_q[$];
    logic [W-1:0] out_log[$];
    logic         last_log[$];
    int pops = 0, stall_seen = 0, in_cnt = 0;
    int done_delay = 2, done_hold = 0;
    int stall_at = -1, stall_left = 0;
    bit rand_ready = 0;

    int last_xfer_cyc, start_rise_cyc, start_fall_cyc, done_cyc, mv_rise_cyc;
    bit done_seen = 0;
    logic prev_start = 1'b0, prev_mv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiply controller stand-in: answers A*B from the presented stores.
    initial begin
        int ccnt;
        int acc;
        ccnt = 0;
        mm_done = 1'b0;
        for (int i = 0; i < NN; i++) result[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mm_done = 1'b0;
                ccnt = 0;
            end else if (mm_start && !mm_done) begin
                if (ccnt >= done_delay) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) begin
                            acc = 0;
                            for (int k = 0; k < N; k++)
                                acc += int'(store_a[r][k]) * int'(store_b[k][c]);
                            result[r*N+c] = acc[W-1:0];
                        end
                    mm_done = 1'b1;
                    ccnt = 0;
                end else ccnt++;
            end else if (!mm_start && mm_done) begin
                if (ccnt >= done_hold) begin
                    mm_done = 1'b0;
                    ccnt = 0;
                end else ccnt++;
            end
        end
    end

    // Sink: ready high, random, or a directed stall at a chosen output index.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bus.m_valid && pops == stall_at) begin
                bus.m_ready = 1'b0;
                stall_left--;
            end else begin
                bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Compare process and event monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.s_ready) check("done_low_in_load", mm_done, 0);
            if (bus.m_valid) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("m_data", bus.m_data, exp_q[0].data);
                    check("m_last", bus.m_last, exp_q[0].last);
                    if (bus.m_ready) begin
                        out_log.push_back(bus.m_data);
                        last_log.push_back(bus.m_last);
                        pops = exp_q[0].last ? 0 : pops + 1;
                        void'(exp_q.pop_front());
                    end else stall_seen++;
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                in_cnt++;
                last_xfer_cyc = cyc;
            end
            if (mm_start && !prev_start) start_rise_cyc = cyc;
            if (!mm_start && prev_start) start_fall_cyc = cyc;
            if (mm_start && mm_done && !done_seen) begin
                done_seen = 1;
                done_cyc = cyc;
            end
            if (bus.m_valid && !prev_mv) mv_rise_cyc = cyc;
        end
        prev_start = mm_start;
        prev_mv = bus.m_valid;
    end

    function automatic void push_expected();
        int acc;
        exp_t e;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc += int'(ta[r][k]) * int'(tbm[k][c]);
                e.data = acc[W-1:0];
                e.last = (r == N - 1) && (c == N - 1);
                exp_q.push_back(e);
            end
    endfunction

    task automatic push(input logic [W-1:0] d, input int gap);
        bit got;
        int guard;
        repeat (gap) begin
            bus.s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.s_data = d;
        bus.s_valid = 1'b1;
        got = 0;
        guard = 0;
        while (!got && guard < 300) begin
            @(negedge clk);
            got = bus.s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!got) check("s_ready_timeout", got, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_matrix(input int gap_mode);
        logic [W-1:0] d;
        int g;
        push_expected();
        for (int k = 0; k < LOAD_COUNT; k++) begin
            d = (k < NN) ? ta[k/N][k%N] : tbm[(k-NN)/N][(k-NN)%N];
            g = (gap_mode == 1 && k > 0) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            push(d, g);
        end
    endtask

    task automatic wait_start_check_stores();
        int guard = 0;
        int bad_a = 0, bad_b = 0;
        while (!mm_start && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("mm_start_seen", mm_start, 1);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (store_a[r][c] !== ta[r][c]) bad_a++;
                if (store_b[r][c] !== tbm[r][c]) bad_b++;
            end
        check("store_a", bad_a, 0);
        check("store_b", bad_b, 0);
        check("busy_in_start", busy, 1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_complete", exp_q.size(), 0);
    endtask

    task automatic rand_mats();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ta[r][c]  = W'($urandom);
                tbm[r][c] = W'($urandom);
            end
    endtask

    initial begin
        int bad;
        int in0;
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_last", bus.m_last, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_busy", busy, 0);
        bad = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (store_a[r][c] !== '0 || store_b[r][c] !== '0) bad++;
        check("rst_stores", bad, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("load_s_ready", bus.s_ready, 1);
        check("load_busy", busy, 0);

        // Identity times 1..9: product equals B, with latency measured.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ta[r][c]  = (r == c) ? W'(1) : W'(0);
                tbm[r][c] = W'(r * N + c + 1);
            end
        out_log.delete();
        last_log.delete();
        done_seen = 0;
        send_matrix(0);
        wait_start_check_stores();
        wait_drain();
        check("lat_start_after_last_in", start_rise_cyc - last_xfer_cyc, 1);
        check("lat_start_fall_after_done", start_fall_cyc - done_cyc, 1);
        check("lat_mvalid_after_done", mv_rise_cyc - done_cyc, 2);
        check("lit_count", out_log.size(), 9);
        if (out_log.size() == 9)
            for (int i = 0; i < 9; i++) begin
                check("lit_data", out_log[i], i + 1);
                check("lit_last", last_log[i], i == 8);
            end

        // Same operands with s_valid toggling between transfers.
        in0 = in_cnt;
        send_matrix(1);
        wait_start_check_stores();
        check("gap_transfer_count", in_cnt - in0, LOAD_COUNT);
        wait_drain();

        // Sink stalls three cycles on output index 4.
        rand_mats();
        stall_seen = 0;
        stall_at = 4;
        stall_left = 3;
        send_matrix(0);
        wait_start_check_stores();
        wait_drain();
        check("stall_cycles", stall_seen, 3);
        stall_at = -1;

        // Reset while draining at index 5 discards the rest.
        rand_mats();
        send_matrix(0);
        wait_start_check_stores();
        bad = 0;
        while (pops != 5 && bad < 300) begin
            @(posedge clk);
            #2;
            bad++;
        end
        check("reached_j5", pops, 5);
        reset = 1'b1;
        #1;
        check("abort_m_valid", bus.m_valid, 0);
        check("abort_mm_start", mm_start, 0);
        check("abort_store_a00", store_a[0][0], 0);
        exp_q.delete();
        pops = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rand_mats();
        send_matrix(0);
        wait_start_check_stores();
        wait_drain();

        // Back-to-back with mm_done held after mm_start falls.
        for (int h = 0; h < 2; h++) begin
            done_hold = (h == 0) ? 4 : 15;
            for (int m = 0; m < 2; m++) begin
                rand_mats();
                send_matrix(0);
                wait_start_check_stores();
            end
            wait_drain();
        end

        // Randomized gaps, sink backpressure and controller timing.
        rand_ready = 1;
        for (int m = 0; m < 6; m++) begin
            done_delay = int'($urandom_range(0, 5));
            done_hold = int'($urandom_range(0, 15));
            rand_mats();
            send_matrix(2);
            wait_start_check_stores();
        end
        wait_drain();
        rand_ready = 0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/matrix_stream_bridge.md
MATRIX_STREAM_BRIDGE -- requirements
Module: matrix_stream_bridge

Interface
REQ-001 Parameter MATRIX_SIZE, default 3, SHALL set the matrix dimension N.
REQ-002 Parameter DATA_SIZE, default 8, SHALL set the element width W.
REQ-003 clk  in  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 s_data  in  W  SHALL carry the inbound operand element.
REQ-006 s_valid  in  1  SHALL mark s_data valid.
REQ-007 s_ready  out  1  SHALL mark the bridge able to accept s_data.
REQ-008 m_data  out  W  SHALL carry the outbound result element.
REQ-009 m_valid  out  1  SHALL mark m_data valid.
REQ-010 m_ready  in  1  SHALL mark the sink able to accept m_data.
REQ-011 m_last  out  1  SHALL mark the final result element of a matrix.
REQ-012 mm_start  out  1  SHALL be the start level to the multiply controller.
REQ-013 mm_done  in  1  SHALL be the done level from the multiply controller.
REQ-014 store_a  out  NxN array of W  SHALL present operand A, indexed [row][col].
REQ-015 store_b  out  NxN array of W  SHALL present operand B, indexed [row][col].
REQ-016 result  in  N*N array of W  SHALL carry the product; element i equals C[i/N][i%N].
REQ-017 busy  out  1  SHALL be high in every state except LOAD.

Function
REQ-018 A transfer SHALL occur on an edge where the valid and ready of the same port are both high; there SHALL be no other transfers.
REQ-019 The FSM SHALL have the states LOAD, START, CAPTURE, DRAIN and RELEASE.
REQ-020 In LOAD, s_ready SHALL be 1, and transfer k (0..2N*N-1) SHALL write A[k/N][k%N] for k<N*N, else B[(k-N*N)/N][(k-N*N)%N].
REQ-021 The transfer counter SHALL be $clog2(2N*N)+1 bits wide and SHALL hold while s_valid is low, so gaps have no effect.
REQ-022 On the final (2N*N-th) transfer, the FSM SHALL go to START and s_ready SHALL be 0 from the next cycle.
REQ-023 In START, mm_start SHALL be 1, and store_a/store_b SHALL stay stable until the next LOAD write.
REQ-024 When mm_done is sampled 1 in START, the FSM SHALL go to CAPTURE.
REQ-025 On the CAPTURE edge, all N*N result elements SHALL be latched into an internal buffer and the FSM SHALL go to DRAIN; mm_start SHALL be 0 in CAPTURE and every later state.
REQ-026 In DRAIN, m_valid SHALL be 1 and m_data SHALL be buffer[j], with j running from 0 to N*N-1 in index order.
REQ-027 j SHALL advance only on a transfer.
REQ-028 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-029 m_last SHALL be 1 only when j=N*N-1.
REQ-030 On the last output transfer, the FSM SHALL go to RELEASE and m_valid SHALL be 0 from the next cycle.
REQ-031 In RELEASE, the FSM SHALL wait until mm_done=0 and then go to LOAD with the transfer counter at 0.
REQ-032 With s_valid held high and m_ready held high, latency SHALL be: mm_start rises 1 cycle after the last input transfer; the first m_valid comes 2 cycles after mm_done is sampled high.
REQ-033 Outside LOAD, s_valid SHALL be ignored; outside DRAIN, m_ready SHALL be ignored.
REQ-034 Products SHALL pass through unmodified, with no width change, rounding or saturation.

Reset
REQ-035 On reset assertion, the FSM SHALL go to LOAD and the counters SHALL be set to 0.
REQ-036 Reset values SHALL be: s_ready=0 during reset, then 1 in LOAD; m_valid=0; m_last=0; mm_start=0; busy=0; m_data=0; store_a and store_b all 0; result buffer all 0.
REQ-037 Reset mid-operation (any state) SHALL abort the operation, and the partial matrix and pending results SHALL be discarded.

Structure
REQ-038 A shared package mm_pkg SHALL hold the MATRIX_SIZE and DATA_SIZE defaults, the state enum and the element-count constants (N*N and 2N*N).
REQ-039 The block SHALL be a single module, with no sub-module.

Verification
REQ-040 A=identity, B=1..9 row-major, controller model returns A*B -> m_data sequence 1,2,..,9; m_last on 9; mm_start high from 1 cycle after the 18th input until CAPTURE.
REQ-041 s_valid toggling 1,0,1,0 across the 18 inputs -> store_a/store_b identical to the gap-free case; only 18 transfers counted.
REQ-042 m_ready low for 3 cycles at j=4 -> m_data=result[4] held stable for those 3 cycles; no element dropped or repeated.
REQ-043 reset pulsed during DRAIN at j=5 -> m_valid=0 and mm_start=0 immediately; next 18 inputs start a fresh matrix at A[0][0].
REQ-044 Back-to-back matrices, with mm_done held high for 4 cycles after mm_start falls -> bridge stays in RELEASE until mm_done=0; the second matrix's results are correct.
